// File: rtl/fifo_sync_flags.sv
// Single-clock synchronous FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, sticky error flags and an optional FWFT read port.
module fifo_sync_flags #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2,
  parameter bit FWFT          = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       clr_err,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [CW-1:0]         count_reg, count_next;
  logic                  full_reg, empty_reg, afull_reg, aempty_reg;
  logic                  overflow_reg, underflow_reg;
  logic                  overflow_next, underflow_next;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  rd_acc, wr_acc;

  always_comb begin
    rd_acc     = rd_en && !empty_reg;
    // A write into a full FIFO only fits if a read frees a slot this cycle.
    wr_acc     = wr_en && (!full_reg || rd_acc);
    rd_ptr_inc = rd_ptr_reg + AW'(1);
    count_next = count_reg;
    if (wr_acc && !rd_acc) begin
      count_next = count_reg + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_next = count_reg - CW'(1);
    end
    overflow_next  = (wr_en && full_reg && !rd_acc) || (overflow_reg && !clr_err);
    underflow_next = (rd_en && empty_reg) || (underflow_reg && !clr_err);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Flags are derived from the next count so they line up with count_reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      afull_reg     <= 1'b0;
      aempty_reg    <= 1'b1;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      count_reg     <= count_next;
      full_reg      <= (count_next == CW'(DEPTH));
      empty_reg     <= (count_next == '0);
      afull_reg     <= (count_next >= CW'(AFULL_THRESH));
      aempty_reg    <= (count_next <= CW'(AEMPTY_THRESH));
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      logic fwft_load, fwft_bypass;
      // The new head comes straight from wdata when the FIFO is empty, or when
      // the only stored word is popped while a new one is written.
      assign fwft_load   = (rd_acc && (count_next != '0)) || (empty_reg && wr_acc);
      assign fwft_bypass = empty_reg || (count_reg == CW'(1));

      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_reg <= '0;
        end else if (fwft_load) begin
          rdata_reg <= fwft_bypass ? wdata : mem[rd_ptr_inc];
        end
      end
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_reg <= '0;
        end else if (rd_acc) begin
          rdata_reg <= mem[rd_ptr_reg];
        end
      end
    end
  endgenerate

  assign rdata        = rdata_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = afull_reg;
  assign almost_empty = aempty_reg;
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Self-checking bench: a standard-mode FIFO driven from a vector table plus
// random traffic against a queue scoreboard, and an FWFT instance for head-of-queue cases.
module tb_fifo_sync_flags;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       wr_en_a = 1'b0, rd_en_a = 1'b0, clr_err_a = 1'b0;
  logic [7:0] wdata_a = '0, rdata_a;
  logic       full_a, empty_a, afull_a, aempty_a, ovf_a, unf_a;
  logic [4:0] count_a;

  logic       wr_en_b = 1'b0, rd_en_b = 1'b0, clr_err_b = 1'b0;
  logic [7:0] wdata_b = '0, rdata_b;
  logic       full_b, empty_b, afull_b, aempty_b, ovf_b, unf_b;
  logic [4:0] count_b;

  always #5 clk = ~clk;

  fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1'b0)) dut_std (
    .clk(clk), .rst(rst), .wr_en(wr_en_a), .wdata(wdata_a), .rd_en(rd_en_a), .rdata(rdata_a),
    .full(full_a), .empty(empty_a), .almost_full(afull_a), .almost_empty(aempty_a),
    .count(count_a), .clr_err(clr_err_a), .overflow(ovf_a), .underflow(unf_a)
  );

  fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1'b1)) dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .wdata(wdata_b), .rd_en(rd_en_b), .rdata(rdata_b),
    .full(full_b), .empty(empty_b), .almost_full(afull_b), .almost_empty(aempty_b),
    .count(count_b), .clr_err(clr_err_b), .overflow(ovf_b), .underflow(unf_b)
  );

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       clr;
    int         cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       unf;
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_rdata = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [7:0] wd, input logic rd, input logic clr,
                              input int cnt, input logic ovf, input logic unf);
    vec_t v;
    v.wr = wr; v.wd = wd; v.rd = rd; v.clr = clr; v.cnt = cnt;
    v.full = (cnt == 16); v.empty = (cnt == 0);
    v.af = (cnt >= 14); v.ae = (cnt <= 2);
    v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  // Drives one cycle on the standard FIFO; the scoreboard queue supplies the expected rdata.
  task automatic step_a(input logic wr, input logic [7:0] wd, input logic rd, input logic clr);
    logic racc, wacc;
    racc = rd && (model_q.size() != 0);
    wacc = wr && ((model_q.size() < 16) || racc);
    if (racc) exp_rdata = model_q.pop_front();
    if (wacc) model_q.push_back(wd);
    wr_en_a = wr; wdata_a = wd; rd_en_a = rd; clr_err_a = clr;
    @(posedge clk); #1;
    wr_en_a = 1'b0; rd_en_a = 1'b0; clr_err_a = 1'b0;
    $display("txn std wr=%0b wd=%02h rd=%0b clr=%0b -> count=%0d rdata=%02h", wr, wd, rd, clr, count_a, rdata_a);
    check("std_rdata", {24'h0, rdata_a}, {24'h0, exp_rdata});
  endtask

  task automatic step_b(input logic wr, input logic [7:0] wd, input logic rd);
    wr_en_b = wr; wdata_b = wd; rd_en_b = rd;
    @(posedge clk); #1;
    wr_en_b = 1'b0; rd_en_b = 1'b0;
    $display("txn fwft wr=%0b wd=%02h rd=%0b -> count=%0d empty=%0b rdata=%02h", wr, wd, rd, count_b, empty_b, rdata_b);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_q.delete();
    exp_rdata = 8'h00;
    $display("txn reset");
  endtask

  vec_t vecs[39];

  initial begin
    for (int i = 0; i < 16; i++) vecs[i] = mk(1'b1, 8'(i), 1'b0, 1'b0, i + 1, 1'b0, 1'b0);
    vecs[16] = mk(1'b1, 8'hAA, 1'b0, 1'b0, 16, 1'b1, 1'b0);
    vecs[17] = mk(1'b0, 8'h00, 1'b0, 1'b1, 16, 1'b0, 1'b0);
    vecs[18] = mk(1'b1, 8'h55, 1'b1, 1'b0, 16, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) vecs[19 + k] = mk(1'b0, 8'h00, 1'b1, 1'b0, 15 - k, 1'b0, 1'b0);
    vecs[35] = mk(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    vecs[36] = mk(1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    vecs[37] = mk(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    vecs[38] = mk(1'b1, 8'h77, 1'b1, 1'b0, 1, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_count", {27'h0, count_a}, 32'd0);
    check("rst_flags", {26'h0, full_a, empty_a, afull_a, aempty_a, ovf_a, unf_a}, 32'b010100);
    check("rst_rdata", {24'h0, rdata_a}, 32'h0);
    check("rst_fwft_empty", {31'h0, empty_b}, 32'd1);

    for (int i = 0; i < 39; i++) begin
      step_a(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr);
      check($sformatf("v%0d_count", i), {27'h0, count_a}, 32'(vecs[i].cnt));
      check($sformatf("v%0d_flags", i), {26'h0, full_a, empty_a, afull_a, aempty_a, ovf_a, unf_a},
            {26'h0, vecs[i].full, vecs[i].empty, vecs[i].af, vecs[i].ae, vecs[i].ovf, vecs[i].unf});
    end

    // Random interleaved traffic; pointers have already wrapped past DEPTH by now.
    for (int i = 0; i < 40; i++) begin
      step_a(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      check($sformatf("rnd%0d_count", i), {27'h0, count_a}, 32'(model_q.size()));
      check($sformatf("rnd%0d_empty", i), {31'h0, empty_a}, {31'h0, model_q.size() == 0});
    end

    // Reset with live contents and a pending error flag.
    pulse_reset();
    step_a(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_rst_unf", {31'h0, unf_a}, 32'd1);
    for (int i = 0; i < 5; i++) step_a(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    check("pre_rst_count", {27'h0, count_a}, 32'd5);
    pulse_reset();
    check("post_rst_count", {27'h0, count_a}, 32'd0);
    check("post_rst_flags", {26'h0, full_a, empty_a, afull_a, aempty_a, ovf_a, unf_a}, 32'b010100);
    step_a(1'b0, 8'h00, 1'b0, 1'b0);
    check("post_rst_idle_count", {27'h0, count_a}, 32'd0);

    // FWFT head-of-queue behaviour.
    step_b(1'b1, 8'h5A, 1'b0);
    check("fwft_first_empty", {31'h0, empty_b}, 32'd0);
    check("fwft_first_rdata", {24'h0, rdata_b}, 32'h5A);
    step_b(1'b1, 8'h5B, 1'b0);
    check("fwft_hold_rdata", {24'h0, rdata_b}, 32'h5A);
    check("fwft_count2", {27'h0, count_b}, 32'd2);
    step_b(1'b0, 8'h00, 1'b1);
    check("fwft_pop_rdata", {24'h0, rdata_b}, 32'h5B);
    check("fwft_count1", {27'h0, count_b}, 32'd1);
    step_b(1'b1, 8'h5C, 1'b1);
    check("fwft_bypass_rdata", {24'h0, rdata_b}, 32'h5C);
    check("fwft_bypass_count", {27'h0, count_b}, 32'd1);
    step_b(1'b0, 8'h00, 1'b1);
    check("fwft_drain_empty", {31'h0, empty_b}, 32'd1);
    check("fwft_drain_rdata", {24'h0, rdata_b}, 32'h5C);
    step_b(1'b0, 8'h00, 1'b1);
    check("fwft_unf", {31'h0, unf_b}, 32'd1);
    check("fwft_unf_rdata", {24'h0, rdata_b}, 32'h5C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
